// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment display driver.
// Latches a hex value and decimal points on a load strobe and scans the
// digits onto one shared segment bus. Each digit slot opens with one dead
// cycle to suppress ghosting. Leading zeros can be blanked, and the segment
// and digit polarities are selectable. All outputs are registered.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic              SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic              DIG_INV    = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF    = {7{SEG_INV}};
    localparam logic              DP_OFF     = SEG_INV;
    localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{DIG_INV}};

    // Scan position
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;

    // Shadow copy of the displayed value
    logic [4*DIGITS-1:0] val_sh_q, val_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;

    // Registered (physical polarity) outputs
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_tick_q, frame_tick_d;

    // Per-digit nibble view of the shadow, and whether each digit shows anything
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   digit_lit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]       = val_sh_q[4*gi +: 4];
            assign digit_lit[gi] = (val_sh_q[4*gi +: 4] != 4'h0) | dp_sh_q[gi];
        end
    endgenerate

    // Hex to active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] s;
        s = 7'b0000000;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Next-state: prescaler/digit advance, shadow capture, output decode
    always_comb begin
        logic       upper_lit;
        logic       blank;
        logic [6:0] seg_log;
        logic       dp_log;
        logic [DIGITS-1:0] dig_log;

        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        val_sh_d = val_sh_q;
        dp_sh_d  = dp_sh_q;
        upper_lit = 1'b0;
        blank     = 1'b0;
        seg_log   = 7'b0000000;
        dp_log    = 1'b0;
        dig_log   = '0;

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            val_sh_d = value;
            dp_sh_d  = dp_in;
        end

        // A digit is a leading zero when it and every digit to its left are
        // unlit; digit 0 always shows so that zero reads as "0".
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_q) && digit_lit[j]) begin
                upper_lit = 1'b1;
            end
        end
        blank = (LZ_BLANK != 0) && (idx_q != '0) && !upper_lit;

        // First cycle of each slot is dead: no digit driven, segments dark
        if (presc_q != '0) begin
            dig_log = DIGITS'(1) << idx_q;
            if (!blank) begin
                seg_log = glyph(nib[idx_q]);
                dp_log  = dp_sh_q[idx_q];
            end
        end

        seg_d        = seg_log ^ SEG_OFF;
        dp_d         = dp_log ^ DP_OFF;
        dig_d        = dig_log ^ DIG_OFF;
        frame_tick_d = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
    end

    // Scan counters: restart at digit 0 on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Shadow registers: reset wins over load
    always_ff @(posedge clk) begin
        if (rst) begin
            val_sh_q <= '0;
            dp_sh_q  <= '0;
        end else begin
            val_sh_q <= val_sh_d;
            dp_sh_q  <= dp_sh_d;
        end
    end

    // Output registers: inactive levels during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_q        <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. Two instances share the stimulus:
//   dut_a: leading-zero blanking, active-high outputs
//   dut_b: no blanking, active-low segments and digits
// A time-based display model predicts each output cycle into a queue; a
// monitor on the falling edge pops and compares.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  dig_a, dig_b;
    logic        ft_a, ft_b;

    seg7_scan_driver #(
        .DIGITS(D), .SCAN_DIV(SD), .LZ_BLANK(1),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg_a), .dp(dp_a), .dig(dig_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(
        .DIGITS(D), .SCAN_DIV(SD), .LZ_BLANK(0),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg_b), .dp(dp_b), .dig(dig_b), .frame_tick(ft_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [6:0] seg_a;
        logic       dp_a;
        logic [3:0] dig_a;
        logic [6:0] seg_b;
        logic       dp_b;
        logic [3:0] dig_b;
        logic       ft;
        logic       chk_seg;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    // Model state: cycles since reset release and the displayed value
    int          mn;
    logic [15:0] msv;
    logic [3:0]  msd;
    logic [6:0]  glyph [16];

    initial begin
        glyph = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                  7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                  7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    end

    task automatic check(input string name, input int cyc,
                         input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Predict the output registered at this edge from the inputs sampled now
    task automatic model_step();
        exp_t       e;
        int         slot, pos;
        logic [3:0] nib;
        logic       lz;
        logic [3:0] ldig;
        cyc_no++;
        e.cyc = cyc_no;
        if (rst) begin
            e.seg_a = 7'h00; e.dp_a = 1'b0; e.dig_a = 4'h0;
            e.seg_b = 7'h7F; e.dp_b = 1'b1; e.dig_b = 4'hF;
            e.ft = 1'b0; e.chk_seg = 1'b1;
            mn  = 0;
            msv = '0;
            msd = '0;
        end else begin
            slot = (mn / SD) % D;
            pos  = mn % SD;
            nib  = 4'((msv >> (4 * slot)) & 16'hF);
            lz   = (slot > 0) && ((msv >> (4 * slot)) == 16'h0) && ((msd >> slot) == 4'h0);
            ldig = (pos == 0) ? 4'h0 : 4'(1 << slot);
            e.dig_a   = ldig;
            e.seg_a   = (pos == 0 || lz) ? 7'h00 : glyph[nib];
            e.dp_a    = (pos == 0 || lz) ? 1'b0 : msd[slot];
            e.dig_b   = ~ldig;
            e.seg_b   = ~glyph[nib];
            e.dp_b    = ~msd[slot];
            e.ft      = ((mn % (SD * D)) == SD * D - 1);
            e.chk_seg = (pos != 0);
            if (load) begin
                msv = value;
                msd = dp_in;
            end
            mn++;
        end
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus, driven just after a falling edge
    task automatic cyc(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        rst   = r;
        load  = l;
        value = v;
        dp_in = d;
        @(posedge clk);
        model_step();
        if (l && !r)
            $display("load cyc=%0d value=%h dp=%b", cyc_no, v, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic load_and_show(input logic [15:0] v, input logic [3:0] d);
        cyc(1'b0, 1'b1, v, d);
        idle(2 * SD * D);
    endtask

    // Monitor: compare every presented output cycle against the prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dig_a", e.cyc, {4'h0, dig_a}, {4'h0, e.dig_a});
                check("dig_b", e.cyc, {4'h0, dig_b}, {4'h0, e.dig_b});
                check("ft_a",  e.cyc, {7'h0, ft_a},  {7'h0, e.ft});
                check("ft_b",  e.cyc, {7'h0, ft_b},  {7'h0, e.ft});
                if (e.chk_seg) begin
                    check("seg_a", e.cyc, {1'b0, seg_a}, {1'b0, e.seg_a});
                    check("dp_a",  e.cyc, {7'h0, dp_a},  {7'h0, e.dp_a});
                    check("seg_b", e.cyc, {1'b0, seg_b}, {1'b0, e.seg_b});
                    check("dp_b",  e.cyc, {7'h0, dp_b},  {7'h0, e.dp_b});
                end
            end
        end
    end

    initial begin
        logic [15:0] rv;
        logic [3:0]  rd;
        int          nz;
        int          guard;
        mn = 0; msv = '0; msd = '0;

        // Reset held for three cycles, then a couple of bare frames
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * SD * D);

        // Directed display patterns
        load_and_show(16'h12AF, 4'b0000);
        load_and_show(16'h0030, 4'b0000);
        load_and_show(16'h0000, 4'b0000);
        load_and_show(16'h0005, 4'b0100);
        load_and_show(16'h0008, 4'b0000);
        load_and_show(16'hF00D, 4'b1001);

        // Reset while digit 2 is being scanned
        guard = 0;
        while (((mn / SD) % D) != 2 && guard < 64) begin
            idle(1);
            guard++;
        end
        cyc(1'b1, 1'b1, 16'hBEEF, 4'hF);
        idle(SD * D + 4);

        // Load mid-slot during digit 0's active cycles
        guard = 0;
        while ((mn % (SD * D)) != 2 && guard < 64) begin
            idle(1);
            guard++;
        end
        cyc(1'b0, 1'b1, 16'h000E, 4'h0);
        idle(SD * D);

        // Load held high across several slots
        for (int i = 0; i < 3 * SD; i++) cyc(1'b0, 1'b1, 16'(i * 16'h0111), 4'(i));
        idle(SD * D);

        // Randomized traffic with sparse loads and occasional resets
        for (int i = 0; i < 3000; i++) begin
            nz = $urandom_range(0, 4);
            rv = 16'($urandom & (32'hFFFF >> (4 * nz)));
            rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0), rv, rd);
        end

        repeat (2) @(negedge clk);
        check("queue_drain", cyc_no, 8'(exp_q.size()), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit 7-segment display driver. Latches a 4·DIGITS-bit hex value plus per-digit decimal points on a load strobe. Time-multiplexes the digits onto one shared segment bus, with programmable scan rate, leading-zero blanking, an anti-ghosting dead cycle and selectable output polarity. Sits between the CPU debug/status registers and the board's common-anode or common-cathode display.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot, legal ≥2.
- LZ_BLANK, 1: 1 = blank leading zero digits.
- SEG_ACTIVE_LOW, 0: 1 = seg/dp outputs active-low.
- DIG_ACTIVE_LOW, 0: 1 = dig outputs active-low.

Ports:
- clk  in  1  system clock; single clock domain, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture value/dp_in into shadow registers.
- value  in  4·DIGITS  hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- seg  out  7  segment pattern {g,f,e,d,c,b,a}.
- dp  out  1  decimal point segment.
- dig  out  DIGITS  digit enables, one-hot when active.
- frame_tick  out  1  one-cycle pulse at end of each full scan.

## Operation
- Shadow registers val_sh and dp_sh load on load=1 and clear on rst. Inputs are ignored when load=0.
- Prescaler presc counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and digit index idx advances. idx wraps from DIGITS-1 to 0.
- Glyph decode, logical (active-high) values {g..a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
  - 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
  - C = 0111001, d = 1011110, E = 1111001, F = 1110001
- Blanking: digit k (k>0) is blanked when all of the following hold:
  - LZ_BLANK=1,
  - val_sh nibbles k..DIGITS-1 are all zero,
  - dp_sh[k..DIGITS-1] are all zero.
- Digit 0 is never blanked, so value 0 displays a single "0".
- A blanked digit drives seg=0000000 and dp=0 (logical). dig is still strobed.
- Dead cycle: when presc==0, logical dig=all-zero.
- Otherwise dig[idx]=1 and seg/dp come from the glyph of nibble idx and dp_sh[idx].
- Polarity: each output is the logical value inverted when its *_ACTIVE_LOW parameter is 1.
- Reset mid-operation:
  - presc, idx, val_sh and dp_sh are cleared.
  - Outputs go inactive the cycle after rst is sampled.
  - The scan restarts at digit 0.

## Timing
- Reset values of all outputs:
  - seg = all-inactive (0000000, or 1111111 if SEG_ACTIVE_LOW).
  - dp = inactive.
  - dig = all-inactive.
  - frame_tick = 0.
- seg, dp, dig and frame_tick are registered. Each is computed from the current presc, idx and shadow, and appears one cycle later.
- Load latency: load sampled at edge N, shadow updated at edge N. The new value is visible on seg at edge N+1, when that digit is in its active slot.
- Slot structure: each digit owns SCAN_DIV consecutive output cycles.
  - The first cycle of the slot is dead (dig inactive).
  - The remaining SCAN_DIV-1 cycles are active.
- A frame is DIGITS·SCAN_DIV cycles.
- frame_tick = 1 for exactly one cycle, registered from (presc==SCAN_DIV-1 && idx==DIGITS-1).
- load coincident with a slot boundary: the new shadow applies from the next output cycle. There is no tearing within a single output cycle.
- load held high: shadow tracks value every cycle.
- rst has priority over load.

## Test plan
All scenarios use DIGITS=4 and SCAN_DIV=4 unless stated.

1. **Reset.** Hold rst=1 for 3 cycles -> seg=0000000, dp=0, dig=0000, frame_tick=0. After release:
   - first active dig=0001 in the 2nd output cycle after release,
   - slot pattern is 1 dead cycle + 3 active cycles per digit,
   - frame_tick pulses every 16 cycles.
2. **Full display.** load value=16'h12AF, dp_in=0 -> glyphs per slot:
   - dig=0001: seg=1110001
   - dig=0010: seg=1110111
   - dig=0100: seg=1011011
   - dig=1000: seg=0000110
3. **Leading-zero blanking.**
   - value=16'h0030 -> digits 3 and 2 give seg=0000000; digit 1 gives 1001111; digit 0 gives 0111111.
   - value=0 -> only digit 0 gives 0111111.
   - With LZ_BLANK=0 and value=0, all four digits give 0111111.
4. **Decimal point overrides blanking.** value=16'h0005, dp_in=4'b0100 ->
   - digit 3 blank,
   - digit 2 seg=0111111 with dp=1,
   - digit 1 seg=0111111 with dp=0,
   - digit 0 seg=1101101.
5. **Active-low polarity.** SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value=16'h0008 ->
   - during reset: seg=1111111, dig=1111,
   - digit 0 active: dig=1110, seg=0000000, dp=1,
   - dead cycle: dig=1111.
6. **Reset mid-frame and load mid-slot.**
   - Assert rst while idx=2 -> next cycle all outputs inactive. After release the scan restarts at dig=0001 and shadow=0 (digit 0 shows 0111111).
   - Separately, pulse load with 16'h000E during digit 0's active cycle -> seg becomes 1111001 exactly one cycle after the load edge.
